mii_phy_decoder: RTL and testbench
==================================

# mii_phy_decoder

Receive-side MII decoder: takes the PHY nibble stream (already synchronized into `i_clk` with a per-nibble sample strobe) and strips preamble and SFD. It assembles bytes low-nibble-first, checks CRC-32 and length, and delivers payload bytes (FCS removed) to the frame-level logic. There is no backpressure, and each frame ends with a one-cycle completion pulse carrying status. It mirrors the transmit encoder on the same link.

## Interface
- `MTU`, 1518, maximum frame length in bytes, FCS included.
- `MIN_FRAME`, 64, minimum frame length in bytes, FCS included.
- `i_clk`  in  1  the single clock; all logic is on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `enet_rx_stb`  in  1  nibble sample strobe; never asserted in two consecutive cycles.
- `enet_rx_dv`  in  1  PHY data valid; sampled only when `enet_rx_stb` is high.
- `enet_rx_er`  in  1  PHY receive error; sampled only when `enet_rx_stb` is high.
- `enet_rx_data`  in  4  PHY nibble; sampled only when `enet_rx_stb` is high.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a payload byte.
- `rx_data`  out  8  payload byte.
- `rx_last`  out  1  qualifies `rx_valid`: this is the final payload byte.
- `rx_done`  out  1  one-cycle pulse, exactly one per frame that passed SFD.
- `rx_status`  out  4  valid with `rx_done`: {`len_err`, `align_err`, `phy_err`, `crc_err`}.
- `rx_len`  out  11  valid with `rx_done`: number of payload bytes emitted.

## Operation
- All outputs reset to 0. Reset lands in DRAIN, so a frame already in progress when reset is released is ignored.
- Input sampling happens only on strobe cycles. "Sample" below means a strobe cycle.
- **DRAIN:** a sample with dv=0 moves to IDLE. No output is produced.
- **IDLE:** a sample with dv=1 and nibble 0x5 moves to PREAMBLE. A sample with dv=1 and any other nibble moves to DRAIN.
- **PREAMBLE:** on each sample:
  - dv=0 → IDLE.
  - nibble 0x5 → stay.
  - nibble 0xD → DATA. Clear the CRC to 0xFFFFFFFF, clear the byte count, the error flags and the nibble phase.
  - any other nibble → DRAIN.
  - The preamble length is not checked.
- **DATA, sample with dv=1:**
  - Phase 0 latches the nibble as bits [3:0].
  - Phase 1 forms a byte (nibble as [7:4]), increments the byte count (saturating at 2047), and feeds the byte to the CRC.
  - `enet_rx_er`=1 on any sample sets `phy_err`.
- **Delay line:** bytes enter a 5-byte delay line. When a byte enters a full line, the oldest byte is emitted, so the 4 FCS bytes plus 1 look-ahead byte are always held back.
- **Long-frame suppression:** bytes whose payload index is 1514 or higher (index counted from 0) are never emitted.
- **DATA, sample with dv=0:** end of frame.
  - If phase is 1, the dangling nibble is discarded and `align_err` is set.
  - If the delay line holds 5 bytes, the oldest byte is emitted with `rx_last`=1, in the same cycle as `rx_done`. Otherwise `rx_done` fires alone.
  - Go to IDLE.
- **`crc_err`:** set when the final CRC register (reflected polynomial 0xEDB88320, not complemented) ≠ 0xDEBB20E3.
- **`len_err`:** set when the byte count < `MIN_FRAME` or > `MTU`. A too-long frame emits no `rx_last`.
- **`rx_len`:** min(count, `MTU`) − 4, floored at 0.
- `enet_rx_er` sampled outside DATA is ignored.

## Timing
- Samples are ≥2 cycles apart, which gives the CRC a full cycle per byte.
- `rx_valid` / `rx_data` are registered: they assert the cycle after the phase-1 sample that pushed the next byte into a full delay line.
- `rx_done`, `rx_status`, `rx_len` and the final `rx_last` assert the cycle after the dv=0 sample. All are single-cycle; `rx_data` holds its value until the next `rx_valid`.
- `i_reset` mid-frame drops the frame: no `rx_done`, all outputs 0 on the next cycle.
- A dv=1 sample arriving while in DRAIN never starts a frame.

## Structure
- Shared package `mii_net_pkg`:
  - CRC constants 0xEDB88320, 0xFFFFFFFF, 0xDEBB20E3.
  - Nibbles 0x5 and 0xD.
  - `MTU` and `MIN_FRAME` defaults.
  - Status-bit index constants.
  - Decoder state enum: DRAIN, IDLE, PREAMBLE, DATA.
- Sub-module: `mii_net_crc32`, the byte-wide running CRC shared with the transmit path.
- The delay line, state machine and counters live in the top module.

## Test plan
- **Good 60-byte frame:** 15×0x5, 0xD, 60 payload bytes 0x00..0x3B, correct FCS, strobe every 2 cycles → 60 `rx_valid` with 0x00..0x3B, `rx_last` on 0x3B with `rx_done`, `rx_status`=0, `rx_len`=60.
- **Bad FCS:** same frame with FCS byte 0 XOR 0x01 → identical data, `rx_status`=4'b0001.
- **PHY error:** `enet_rx_er` high on one sample mid-payload → data intact, `rx_status`=4'b0010. A second frame with er high only between frames → status 0.
- **Runt and odd-nibble frames:**
  - 10 total bytes with good FCS → 6 bytes out, `rx_last` on the 6th, `rx_status`=4'b1000, `rx_len`=6.
  - Good 64-byte frame plus one extra nibble → `rx_status`=4'b0100.
- **Long frame:** 1600-byte frame → exactly 1514 `rx_valid`, no `rx_last`, `rx_done` with `len_err`=1, `rx_len`=1514.
- **Reset mid-frame:** assert `i_reset` at byte 20 while dv stays high → no further output until dv drops; the next good frame decodes with status 0.

Source files
------------

// File: rtl/mii_net_pkg.sv
// Shared MII receive/transmit constants, decoder state encoding and the
// reflected byte-wide CRC-32 step.
package mii_net_pkg;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  localparam int MTU_DEF       = 1518;
  localparam int MIN_FRAME_DEF = 64;

  localparam int ST_CRC   = 0;
  localparam int ST_PHY   = 1;
  localparam int ST_ALIGN = 2;
  localparam int ST_LEN   = 3;

  typedef enum logic [1:0] {DRAIN, IDLE, PREAMBLE, DATA} dec_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction
endpackage

// File: rtl/mii_net_crc32.sv
// Byte-wide running CRC-32 (reflected, uncomplemented register).
module mii_net_crc32
  import mii_net_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  always_ff @(posedge clk) begin
    if (reset || init) crc <= CRC_INIT;
    else if (en)       crc <= crc32_byte(crc, data);
  end
endmodule

// File: rtl/mii_phy_decoder.sv
// MII receive decoder: strips preamble/SFD, assembles bytes, holds back the
// FCS through a 5-byte delay line and reports per-frame status.
module mii_phy_decoder
  import mii_net_pkg::*;
#(
  parameter int MTU       = MTU_DEF,
  parameter int MIN_FRAME = MIN_FRAME_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        enet_rx_stb,
  input  logic        enet_rx_dv,
  input  logic        enet_rx_er,
  input  logic [3:0]  enet_rx_data,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_last,
  output logic        rx_done,
  output logic [3:0]  rx_status,
  output logic [10:0] rx_len
);
  localparam logic [10:0] MTU_W  = 11'(MTU);
  localparam logic [10:0] MIN_W  = 11'(MIN_FRAME);
  // Oldest byte in a full line has index count-5; it is emitted only below MTU-4.
  localparam logic [10:0] EMIT_W = 11'(MTU + 1);

  dec_state_e       state, state_nxt;
  logic             frame_start, nib_take, byte_push, frame_end;
  logic             phase, phy_err;
  logic [3:0]       lo_nib;
  logic [10:0]      count, cnt_cap, len_calc;
  logic [2:0]       fill;
  logic [4:0][7:0]  dly;
  logic [31:0]      crc;
  logic [7:0]       byte_in;

  assign byte_in = {enet_rx_data, lo_nib};

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= DRAIN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enet_rx_stb) begin
      unique case (state)
        DRAIN:    if (!enet_rx_dv) state_nxt = IDLE;
        IDLE:     if (enet_rx_dv)
                    state_nxt = (enet_rx_data == NIB_PRE) ? PREAMBLE : DRAIN;
        PREAMBLE: if (!enet_rx_dv)                 state_nxt = IDLE;
                  else if (enet_rx_data == NIB_SFD) state_nxt = DATA;
                  else if (enet_rx_data != NIB_PRE) state_nxt = DRAIN;
        DATA:     if (!enet_rx_dv) state_nxt = IDLE;
        default:  state_nxt = DRAIN;
      endcase
    end
  end

  always_comb begin
    frame_start = enet_rx_stb && state == PREAMBLE && enet_rx_dv && enet_rx_data == NIB_SFD;
    nib_take    = enet_rx_stb && state == DATA && enet_rx_dv;
    byte_push   = nib_take && phase;
    frame_end   = enet_rx_stb && state == DATA && !enet_rx_dv;
    cnt_cap     = (count > MTU_W) ? MTU_W : count;
    len_calc    = (cnt_cap < 11'd4) ? 11'd0 : cnt_cap - 11'd4;
  end

  mii_net_crc32 u_crc (
    .clk   (i_clk),
    .reset (i_reset),
    .init  (frame_start),
    .en    (byte_push),
    .data  (byte_in),
    .crc   (crc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_last   <= 1'b0;
      rx_done   <= 1'b0;
      rx_status <= '0;
      rx_len    <= '0;
      phase     <= 1'b0;
      phy_err   <= 1'b0;
      lo_nib    <= '0;
      count     <= '0;
      fill      <= '0;
      dly       <= '0;
    end else begin
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      rx_done   <= 1'b0;
      rx_status <= '0;
      rx_len    <= '0;
      if (frame_start) begin
        phase   <= 1'b0;
        phy_err <= 1'b0;
        count   <= '0;
        fill    <= '0;
      end
      if (nib_take) begin
        phase <= ~phase;
        if (!phase)     lo_nib  <= enet_rx_data;
        if (enet_rx_er) phy_err <= 1'b1;
      end
      if (byte_push) begin
        if (count != 11'h7FF) count <= count + 11'd1;
        dly <= {dly[3:0], byte_in};
        if (fill != 3'd5) fill <= fill + 3'd1;
        else if (count < EMIT_W) begin
          rx_valid <= 1'b1;
          rx_data  <= dly[4];
        end
      end
      if (frame_end) begin
        rx_done             <= 1'b1;
        rx_status[ST_CRC]   <= (crc != CRC_RESIDUE);
        rx_status[ST_PHY]   <= phy_err;
        rx_status[ST_ALIGN] <= phase;
        rx_status[ST_LEN]   <= (count < MIN_W) || (count > MTU_W);
        rx_len              <= len_calc;
        if (fill == 3'd5 && count < EMIT_W) begin
          rx_valid <= 1'b1;
          rx_last  <= 1'b1;
          rx_data  <= dly[4];
        end
      end
    end
  end
endmodule

// File: tb/tb_mii_phy_decoder.sv
// Scoreboard bench for mii_phy_decoder: frames are built with an FCS model,
// expected bytes/status queued at drive time and matched by an output monitor.
module tb_mii_phy_decoder;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        enet_rx_stb, enet_rx_dv, enet_rx_er;
  logic [3:0]  enet_rx_data;
  logic        rx_valid, rx_last, rx_done;
  logic [7:0]  rx_data;
  logic [3:0]  rx_status;
  logic [10:0] rx_len;

  typedef struct packed { logic [7:0] d; logic last; } byte_exp_t;
  typedef struct packed { logic [3:0] st; logic [10:0] len; } done_exp_t;

  byte_exp_t  exp_q[$];
  done_exp_t  done_q[$];
  logic [7:0] frm[$];
  int n_cmp = 0, n_bad = 0;

  always #5 i_clk = ~i_clk;

  mii_phy_decoder dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .enet_rx_stb  (enet_rx_stb),
    .enet_rx_dv   (enet_rx_dv),
    .enet_rx_er   (enet_rx_er),
    .enet_rx_data (enet_rx_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_last      (rx_last),
    .rx_done      (rx_done),
    .rx_status    (rx_status),
    .rx_len       (rx_len)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // One strobed sample followed by a quiet cycle.
  task automatic nib(input logic dv, input logic er, input logic [3:0] d);
    @(negedge i_clk);
    enet_rx_stb = 1'b1; enet_rx_dv = dv; enet_rx_er = er; enet_rx_data = d;
    @(negedge i_clk);
    enet_rx_stb = 1'b0;
  endtask

  task automatic build(input int npay, input logic bad_fcs);
    logic [31:0] c, fcs;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      frm.push_back(8'(i));
      c = crc_step(c, 8'(i));
    end
    fcs = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (bad_fcs) frm[npay] = frm[npay] ^ 8'h01;
  endtask

  task automatic send_frame(input int npay, input logic bad_fcs, input int er_byte,
                            input logic extra_nib, input logic gap_er);
    int n, ecnt, capn;
    build(npay, bad_fcs);
    n    = frm.size();
    ecnt = (n >= 5) ? ((n - 4 > 1514) ? 1514 : n - 4) : 0;
    for (int i = 0; i < ecnt; i++)
      exp_q.push_back('{d: frm[i], last: (i == n - 5) && (n <= 1518)});
    capn = (n > 1518) ? 1518 : n;
    done_q.push_back('{st: {(n < 64 || n > 1518), extra_nib, (er_byte >= 0), bad_fcs},
                       len: 11'((capn < 4) ? 0 : capn - 4)});
    nib(1'b0, gap_er, 4'h0);
    nib(1'b0, gap_er, 4'h0);
    for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < n; i++) begin
      nib(1'b1, (i == er_byte), frm[i][3:0]);
      nib(1'b1, 1'b0, frm[i][7:4]);
    end
    if (extra_nib) nib(1'b1, 1'b0, 4'hA);
    nib(1'b0, 1'b0, 4'h0);
    nib(1'b0, gap_er, 4'h0);
  endtask

  always @(negedge i_clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) chk("extra_valid", 32'(rx_valid), 32'd0);
      else begin
        byte_exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.d));
        chk("rx_last", 32'(rx_last), 32'(e.last));
      end
    end
    if (rx_done) begin
      if (done_q.size() == 0) chk("extra_done", 32'(rx_done), 32'd0);
      else begin
        done_exp_t e;
        e = done_q.pop_front();
        chk("rx_status", 32'(rx_status), 32'(e.st));
        chk("rx_len", 32'(rx_len), 32'(e.len));
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    enet_rx_stb = 1'b0; enet_rx_dv = 1'b0; enet_rx_er = 1'b0; enet_rx_data = 4'h0;
    repeat (3) @(negedge i_clk);
    chk("reset_out", {rx_valid, rx_last, rx_done, rx_status, rx_len, rx_data}, 32'd0);
    i_reset = 1'b0;

    send_frame(60, 1'b0, -1, 1'b0, 1'b0);   // good
    send_frame(60, 1'b1, -1, 1'b0, 1'b0);   // bad FCS
    send_frame(60, 1'b0, 30, 1'b0, 1'b0);   // PHY error mid-payload
    send_frame(60, 1'b0, -1, 1'b0, 1'b1);   // er only between frames
    send_frame(6,  1'b0, -1, 1'b0, 1'b0);   // runt
    send_frame(60, 1'b0, -1, 1'b1, 1'b0);   // odd nibble
    send_frame(1596, 1'b0, -1, 1'b0, 1'b0); // too long

    // Reset mid-frame: bytes emitted before reset are expected, nothing after.
    build(60, 1'b0);
    for (int i = 0; i < 15; i++) exp_q.push_back('{d: frm[i], last: 1'b0});
    nib(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 20; i++) begin
      nib(1'b1, 1'b0, frm[i][3:0]);
      nib(1'b1, 1'b0, frm[i][7:4]);
    end
    @(negedge i_clk); i_reset = 1'b1;
    @(negedge i_clk); i_reset = 1'b0;
    chk("reset_mid_out", {rx_valid, rx_last, rx_done, rx_status, rx_len, rx_data}, 32'd0);
    for (int i = 20; i < 40; i++) begin
      nib(1'b1, 1'b0, frm[i][3:0]);
      nib(1'b1, 1'b0, frm[i][7:4]);
    end
    nib(1'b0, 1'b0, 4'h0);
    send_frame(60, 1'b0, -1, 1'b0, 1'b0);   // recovers cleanly

    repeat (20) @(negedge i_clk);
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
